prio_mixer_n: RTL and testbench
===============================

# prio_mixer_n

Parametrised N-layer priority mixer for the Taito F2 video path, sitting after the tilemap and sprite generators and ahead of the palette RAM. Each pixel clock it takes one colour word per layer, looks up a 4-bit priority per layer from CPU-programmed tables, and selects the winning colour. It optionally forms a blend code from the top two layers. CPU writes land in shadow registers that commit to the active set at vblank start, or immediately when IMM mode is set, so priority changes never tear mid-frame.

## Interface
- NUM_LAYERS, 4, number of input layers, 2..8.
- COLOR_W, 12, palette index width per layer, ≥6.
- SEL_W, 2, per-pixel priority-select field width; table has 2^SEL_W entries.
- ADDR_W, 5, CPU address width; must cover 2 + NUM_LAYERS·2^SEL_W/2 byte registers.
- Clock/reset (already decided): one clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_pixel  in  1  pixel enable; the pipeline advances only when high.
- vblank  in  1  vertical blank, level; its rising edge triggers the commit.
- cs  in  1  CPU chip select.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDR_W  byte register index.
- cpu_ds_n  in  2  data strobes, active low; only [0] gates writes.
- cpu_din  in  8  write data.
- cpu_dout  out  8  registered read data.
- color_in  in  NUM_LAYERS·(SEL_W+COLOR_W)  layer i occupies slice i: {sel, colour}.
- color_out  out  COLOR_W  mixed palette index.

## Operation
- Reg 0 (CTRL), always applied immediately:
  - bit7 is BLEND.
  - bit6 is MODE (1 = nibble splice, 0 = bit-5 clear).
  - bit0 is IMM.
- Reg 1 (STATUS), read-only: bit0 is PENDING. Writes to reg 1 are ignored.
- Regs 2+: priority tables, 4 bits per entry. Layer i, entry s is at byte 2 + (i·2^SEL_W + s)/2; the low nibble holds even s, the high nibble odd s.
- Write (cs & ~cpu_rw & ~cpu_ds_n[0]) to a table register:
  - Updates the shadow copy.
  - If IMM = 0, sets PENDING.
  - If IMM = 1, also updates the active copy in the same cycle; PENDING is unchanged.
- Out-of-range addresses: writes are ignored, reads return 0.
- Read (cs & cpu_rw): cpu_dout takes the shadow value on the next edge; reg 1 returns {7'b0, PENDING}.
- Commit:
  - vblank is registered and a rising edge is detected.
  - On that edge, if PENDING = 1, the whole shadow table is copied to active and PENDING clears.
  - If a CPU write coincides with the commit cycle, the commit uses the pre-write shadow. The write lands in the shadow and leaves PENDING = 1.
- Per-layer priority: p_i = active[i][sel_i] if colour[3:0] ≠ 0 (opaque), otherwise 0.
- Selection:
  - top = highest p_i; second = highest p_j with j ≠ top.
  - Ties go to the lower index.
  - If all p_i = 0, output layer 0's colour unchanged.
- Blend applies when BLEND = 1, p_second ≠ 0 and p_second == p_top − 1 (4-bit, no wrap: p_top = 0 never blends).
  - MODE = 1: out = {top[COLOR_W-1:4], second[3:0]}.
  - MODE = 0: out = top with bit 5 forced to 0.
- Otherwise out = top colour.

## Timing
- Reset values: all shadow and active registers 0, PENDING 0, cpu_dout 0, color_out 0, all pipeline stages 0, and the vblank edge register 0.
- Pipeline runs in three ce_pixel-qualified stages:
  - S1 registers p_i and the colours.
  - S2 registers top and second.
  - S3 registers color_out.
- Latency is 3 ce_pixel pulses from input to color_out. When ce_pixel is low, all stages hold.
- An active-table change (commit or IMM write) affects S1 on the next ce_pixel after the updating edge.
- Reset asserted mid-frame clears everything asynchronously; the outputs read 0 until 3 ce_pixel pulses after release.
- cpu_dout is valid 1 clk after the read cycle and holds until the next read.

## Test plan
- Reset, then read regs 0–5 → all 0x00; color_out = 0 for the first 3 ce_pixel pulses.
- IMM = 0, write reg 2 = 0x21, two layers with colours 0x011 / 0x022 and sel 0, layer0 entry 0 = 1, layer1 entry 0 = 0 → output stays layer 0 while the active table is zero; STATUS = 1. Pulse vblank → STATUS = 0; from the next ce_pixel, 3 pulses later, output = 0x011.
- Layer1 priority 5 vs layer0 priority 3, both opaque, BLEND = 0 → out = layer1 colour. Make layer1's colour[3:0] = 0 → out = layer0 colour after 3 pulses.
- BLEND = 1, MODE = 1, top colour 0xAB7, second 0x123 with priorities 6 and 5 → out = 0xAB3. With MODE = 0 → out = 0xA97 (bit 5 cleared).
- Tie at priority 4 between layers 2 and 3 → layer 2 wins. All layers transparent → out = layer 0's raw colour.
- CPU write on the same clk as the vblank rising edge with PENDING = 1 → the old shadow commits and PENDING remains 1. Hold ce_pixel low for 10 clks → color_out is frozen throughout.

Source files
------------

// File: rtl/prio_mixer_n_if.sv
// Bus bundle for prio_mixer_n: CPU register port, pixel timing strobes and
// the per-layer colour inputs with the mixed colour output.
interface prio_mixer_n_if #(
   parameter int NUM_LAYERS = 4,
   parameter int COLOR_W    = 12,
   parameter int SEL_W      = 2,
   parameter int ADDR_W     = 5
) ();

   logic                                  ce_pixel;
   logic                                  vblank;
   logic                                  cs;
   logic                                  cpu_rw;
   logic [ADDR_W-1:0]                     cpu_addr;
   logic [1:0]                            cpu_ds_n;
   logic [7:0]                            cpu_din;
   logic [7:0]                            cpu_dout;
   logic [NUM_LAYERS*(SEL_W+COLOR_W)-1:0] color_in;
   logic [COLOR_W-1:0]                    color_out;

   // Driver side: CPU/video source.
   modport master (
      output ce_pixel, vblank, cs, cpu_rw, cpu_addr, cpu_ds_n, cpu_din, color_in,
      input  cpu_dout, color_out
   );

   // Mixer side.
   modport slave (
      input  ce_pixel, vblank, cs, cpu_rw, cpu_addr, cpu_ds_n, cpu_din, color_in,
      output cpu_dout, color_out
   );

endinterface

// File: rtl/prio_mixer_n.sv
// N-layer priority mixer. Each layer's colour is ranked through a 4-bit
// priority table indexed by its per-pixel select field; the winner (optionally
// blended with the runner-up) goes to the palette. CPU table writes land in a
// shadow copy that is committed to the active copy at vblank start, or at once
// in IMM mode, so the picture never tears mid-frame.
module prio_mixer_n #(
   parameter int NUM_LAYERS = 4,
   parameter int COLOR_W    = 12,
   parameter int SEL_W      = 2,
   parameter int ADDR_W     = 5
) (
   input logic           clk,
   input logic           reset,
   prio_mixer_n_if.slave bus
);

   localparam int ENTRIES   = 2 ** SEL_W;
   localparam int TBL_BYTES = NUM_LAYERS * ENTRIES / 2;
   localparam int LW        = SEL_W + COLOR_W;
   localparam int LT_W      = ENTRIES * 4;

   logic [7:0]               ctrl;
   logic                     pending;
   logic                     vblank_q;
   logic [TBL_BYTES*8-1:0]   shadow_tbl;
   logic [TBL_BYTES*8-1:0]   active_tbl;
   logic                     wr_en;
   logic                     rd_en;
   logic                     commit;
   logic [7:0]               rd_data;
   logic                     unused_ds;

   logic [NUM_LAYERS*4-1:0]       p_now;
   logic [NUM_LAYERS*4-1:0]       p_s1;
   logic [NUM_LAYERS*COLOR_W-1:0] col_now;
   logic [NUM_LAYERS*COLOR_W-1:0] col_s1;

   int                 top_idx;
   int                 sec_idx;
   logic [3:0]         top_p;
   logic [3:0]         sec_p;
   logic [COLOR_W-1:0] top_c;
   logic [COLOR_W-1:0] sec_c;
   logic [3:0]         top_p_s2;
   logic [3:0]         sec_p_s2;
   logic [COLOR_W-1:0] top_c_s2;
   logic [COLOR_W-1:0] sec_c_s2;

   logic               blend_en;
   logic [COLOR_W-1:0] mixed;
   logic [COLOR_W-1:0] color_q;

   assign wr_en     = bus.cs & ~bus.cpu_rw & ~bus.cpu_ds_n[0];
   assign rd_en     = bus.cs & bus.cpu_rw;
   assign unused_ds = bus.cpu_ds_n[1];
   assign commit    = bus.vblank & ~vblank_q & pending;

   assign bus.color_out = color_q;

   // Read-back mux: CTRL, STATUS, then the shadow table bytes; anything else reads 0.
   always_comb begin
      rd_data = '0;
      if (bus.cpu_addr == ADDR_W'(0)) begin
         rd_data = ctrl;
      end else if (bus.cpu_addr == ADDR_W'(1)) begin
         rd_data = {7'b0, pending};
      end
      for (int b = 0; b < TBL_BYTES; b++) begin
         if (bus.cpu_addr == ADDR_W'(b + 2)) begin
            rd_data = shadow_tbl[b*8 +: 8];
         end
      end
   end

   // Register file: commit runs first so a coinciding CPU write lands on top of
   // it, leaving the pre-write shadow in the active copy and PENDING set again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl       <= '0;
         pending    <= 1'b0;
         vblank_q   <= 1'b0;
         shadow_tbl <= '0;
         active_tbl <= '0;
         bus.cpu_dout <= '0;
      end else begin
         vblank_q <= bus.vblank;
         if (commit) begin
            active_tbl <= shadow_tbl;
            pending    <= 1'b0;
         end
         if (wr_en) begin
            if (bus.cpu_addr == ADDR_W'(0)) begin
               ctrl <= bus.cpu_din;
            end
            for (int b = 0; b < TBL_BYTES; b++) begin
               if (bus.cpu_addr == ADDR_W'(b + 2)) begin
                  shadow_tbl[b*8 +: 8] <= bus.cpu_din;
                  if (ctrl[0]) begin
                     active_tbl[b*8 +: 8] <= bus.cpu_din;
                  end else begin
                     pending <= 1'b1;
                  end
               end
            end
         end
         if (rd_en) begin
            bus.cpu_dout <= rd_data;
         end
      end
   end

   // Per-layer priority lookup; a transparent pixel (low nibble zero) ranks 0.
   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
      logic [LT_W-1:0]    layer_tbl;
      logic [SEL_W-1:0]   sel;
      logic [COLOR_W-1:0] col;

      assign layer_tbl = active_tbl[g*LT_W +: LT_W];
      assign sel       = bus.color_in[g*LW + COLOR_W +: SEL_W];
      assign col       = bus.color_in[g*LW +: COLOR_W];

      assign col_now[g*COLOR_W +: COLOR_W] = col;
      assign p_now[g*4 +: 4] = (col[3:0] != 4'd0) ? layer_tbl[{sel, 2'b00} +: 4] : 4'd0;
   end

   // Stage 1: capture priorities and colours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_s1   <= '0;
         col_s1 <= '0;
      end else if (bus.ce_pixel) begin
         p_s1   <= p_now;
         col_s1 <= col_now;
      end
   end

   // Rank layers: strict comparison keeps the lower index on ties, and with all
   // priorities zero the winner naturally stays layer 0.
   always_comb begin
      top_idx = 0;
      top_p   = p_s1[3:0];
      for (int i = 1; i < NUM_LAYERS; i++) begin
         if (p_s1[i*4 +: 4] > top_p) begin
            top_p   = p_s1[i*4 +: 4];
            top_idx = i;
         end
      end
      sec_idx = (top_idx == 0) ? 1 : 0;
      sec_p   = 4'd0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if ((i != top_idx) && (p_s1[i*4 +: 4] > sec_p)) begin
            sec_p   = p_s1[i*4 +: 4];
            sec_idx = i;
         end
      end
      top_c = col_s1[top_idx*COLOR_W +: COLOR_W];
      sec_c = col_s1[sec_idx*COLOR_W +: COLOR_W];
   end

   // Stage 2: capture the top and runner-up layers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         top_p_s2 <= '0;
         sec_p_s2 <= '0;
         top_c_s2 <= '0;
         sec_c_s2 <= '0;
      end else if (bus.ce_pixel) begin
         top_p_s2 <= top_p;
         sec_p_s2 <= sec_p;
         top_c_s2 <= top_c;
         sec_c_s2 <= sec_c;
      end
   end

   // Blend only when the runner-up sits exactly one level below the winner;
   // CTRL bits act live on this stage.
   always_comb begin
      blend_en = ctrl[7] && (sec_p_s2 != 4'd0) && (sec_p_s2 == top_p_s2 - 4'd1);
      mixed    = top_c_s2;
      if (blend_en) begin
         if (ctrl[6]) begin
            mixed = {top_c_s2[COLOR_W-1:4], sec_c_s2[3:0]};
         end else begin
            mixed[5] = 1'b0;
         end
      end
   end

   // Stage 3: registered palette index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         color_q <= '0;
      end else if (bus.ce_pixel) begin
         color_q <= mixed;
      end
   end

endmodule

// File: tb/tb_prio_mixer_n.sv
// Directed bench for prio_mixer_n: register access, commit timing, ranking,
// blending, pipeline freeze and asynchronous reset.
module tb_prio_mixer_n;

   localparam int NUM_LAYERS = 4;
   localparam int COLOR_W    = 12;
   localparam int SEL_W      = 2;
   localparam int ADDR_W     = 5;
   localparam int LW         = SEL_W + COLOR_W;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic [NUM_LAYERS*LW-1:0] pix = '0;
   logic [7:0] rd;

   prio_mixer_n_if #(
      .NUM_LAYERS(NUM_LAYERS), .COLOR_W(COLOR_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W)
   ) bus ();

   prio_mixer_n #(
      .NUM_LAYERS(NUM_LAYERS), .COLOR_W(COLOR_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Count a comparison and report any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Set one layer's {sel, colour} and drive the whole input bus.
   task automatic applyStimulus(input int layer, input logic [SEL_W-1:0] sel, input logic [COLOR_W-1:0] col);
      pix[layer*LW +: LW] = {sel, col};
      bus.color_in = pix;
   endtask

   task automatic cpuWrite(input logic [ADDR_W-1:0] addr, input logic [7:0] data, input logic [1:0] ds);
      @(negedge clk);
      bus.cs       = 1'b1;
      bus.cpu_rw   = 1'b0;
      bus.cpu_ds_n = ds;
      bus.cpu_addr = addr;
      bus.cpu_din  = data;
      @(negedge clk);
      bus.cs       = 1'b0;
      bus.cpu_ds_n = 2'b11;
   endtask

   task automatic cpuRead(input logic [ADDR_W-1:0] addr, output logic [7:0] data);
      @(negedge clk);
      bus.cs       = 1'b1;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = addr;
      @(negedge clk);
      bus.cs       = 1'b0;
      data         = bus.cpu_dout;
   endtask

   task automatic readCheck(input string tag, input logic [ADDR_W-1:0] addr, input logic [7:0] exp);
      cpuRead(addr, rd);
      checkOutput(tag, {24'd0, rd}, {24'd0, exp});
   endtask

   task automatic pixelPulses(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.ce_pixel = 1'b1;
         @(negedge clk);
         bus.ce_pixel = 1'b0;
      end
   endtask

   task automatic pixelCheck(input string tag, input logic [COLOR_W-1:0] exp);
      pixelPulses(3);
      checkOutput(tag, {20'd0, bus.color_out}, {20'd0, exp});
   endtask

   task automatic vblankPulse();
      @(negedge clk);
      bus.vblank = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.vblank = 1'b0;
      @(negedge clk);
   endtask

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      reset        = 1'b1;
      bus.ce_pixel = 1'b0;
      bus.vblank   = 1'b0;
      bus.cs       = 1'b0;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = '0;
      bus.cpu_ds_n = 2'b11;
      bus.cpu_din  = '0;
      bus.color_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_out", {20'd0, bus.color_out}, 32'h0);
      for (int r = 0; r < 6; r++) begin
         readCheck("reset_reg", ADDR_W'(r), 8'h00);
      end

      // Pipeline fill after reset: two zero pulses, valid on the third.
      applyStimulus(0, 2'd0, 12'h011);
      pixelPulses(1);
      checkOutput("fill_p1", {20'd0, bus.color_out}, 32'h0);
      pixelPulses(1);
      checkOutput("fill_p2", {20'd0, bus.color_out}, 32'h0);
      pixelPulses(1);
      checkOutput("fill_p3", {20'd0, bus.color_out}, 32'h011);

      // Ignored accesses: out of range, STATUS write, gated strobe.
      cpuWrite(5'd12, 8'hFF, 2'b10);
      readCheck("oor_read", 5'd12, 8'h00);
      cpuWrite(5'd1, 8'hFF, 2'b10);
      readCheck("status_wr", 5'd1, 8'h00);
      cpuWrite(5'd2, 8'h5A, 2'b01);
      readCheck("ds_gated", 5'd2, 8'h00);

      // Shadow write then vblank commit.
      cpuWrite(5'd2, 8'h21, 2'b10);
      readCheck("pending_set", 5'd1, 8'h01);
      applyStimulus(1, 2'd0, 12'h022);
      pixelCheck("pre_commit", 12'h011);
      readCheck("shadow_rd", 5'd2, 8'h21);
      vblankPulse();
      readCheck("pending_clr", 5'd1, 8'h00);
      pixelCheck("post_commit", 12'h011);

      // IMM writes: layer1 prio 5 beats layer0 prio 3.
      cpuWrite(5'd0, 8'h01, 2'b10);
      cpuWrite(5'd2, 8'h03, 2'b10);
      cpuWrite(5'd4, 8'h05, 2'b10);
      readCheck("imm_nopend", 5'd1, 8'h00);
      pixelCheck("prio_l1", 12'h022);
      applyStimulus(1, 2'd0, 12'h020);
      pixelCheck("transp_l1", 12'h011);

      // Blending of top (prio 6) with runner-up (prio 5).
      cpuWrite(5'd0, 8'hC1, 2'b10);
      cpuWrite(5'd2, 8'h05, 2'b10);
      cpuWrite(5'd4, 8'h06, 2'b10);
      applyStimulus(0, 2'd0, 12'h123);
      applyStimulus(1, 2'd0, 12'hAB7);
      pixelCheck("blend_splice", 12'hAB3);
      cpuWrite(5'd0, 8'h81, 2'b10);
      pixelCheck("blend_bit5", 12'hA97);
      cpuWrite(5'd2, 8'h04, 2'b10);
      pixelCheck("no_blend_gap", 12'hAB7);

      // Ties, select indexing, all transparent.
      cpuWrite(5'd0, 8'h01, 2'b10);
      cpuWrite(5'd2, 8'h00, 2'b10);
      cpuWrite(5'd4, 8'h00, 2'b10);
      cpuWrite(5'd6, 8'h04, 2'b10);
      cpuWrite(5'd8, 8'h74, 2'b10);
      applyStimulus(0, 2'd0, 12'h011);
      applyStimulus(1, 2'd0, 12'h022);
      applyStimulus(2, 2'd0, 12'h033);
      applyStimulus(3, 2'd0, 12'h044);
      pixelCheck("tie_l2", 12'h033);
      applyStimulus(3, 2'd1, 12'h044);
      pixelCheck("sel1_l3", 12'h044);
      applyStimulus(0, 2'd0, 12'h120);
      applyStimulus(1, 2'd0, 12'h230);
      applyStimulus(2, 2'd0, 12'h340);
      applyStimulus(3, 2'd1, 12'h450);
      pixelCheck("all_transp", 12'h120);

      // CPU write on the commit cycle: old shadow commits, PENDING stays.
      cpuWrite(5'd0, 8'h00, 2'b10);
      cpuWrite(5'd2, 8'h09, 2'b10);
      readCheck("pend_again", 5'd1, 8'h01);
      @(negedge clk);
      bus.vblank   = 1'b1;
      bus.cs       = 1'b1;
      bus.cpu_rw   = 1'b0;
      bus.cpu_ds_n = 2'b10;
      bus.cpu_addr = 5'd4;
      bus.cpu_din  = 8'h0A;
      @(negedge clk);
      bus.cs       = 1'b0;
      bus.cpu_ds_n = 2'b11;
      readCheck("coincide_pend", 5'd1, 8'h01);
      readCheck("coincide_shadow", 5'd4, 8'h0A);
      applyStimulus(0, 2'd0, 12'h011);
      applyStimulus(1, 2'd0, 12'h022);
      applyStimulus(2, 2'd0, 12'h030);
      applyStimulus(3, 2'd0, 12'h040);
      pixelCheck("coincide_old", 12'h011);
      @(negedge clk);
      bus.vblank = 1'b0;
      vblankPulse();
      readCheck("second_commit", 5'd1, 8'h00);
      pixelCheck("coincide_new", 12'h022);

      // ce_pixel low: output frozen.
      applyStimulus(0, 2'd0, 12'h055);
      applyStimulus(1, 2'd0, 12'h0A0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("freeze", {20'd0, bus.color_out}, 32'h022);
      end
      pixelCheck("unfreeze", 12'h055);

      // Asynchronous reset mid-frame.
      @(negedge clk);
      #2 reset = 1'b1;
      #1 checkOutput("async_rst", {20'd0, bus.color_out}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      readCheck("rst_status", 5'd1, 8'h00);
      readCheck("rst_tbl", 5'd4, 8'h00);
      readCheck("rst_ctrl", 5'd0, 8'h00);
      pixelPulses(2);
      checkOutput("rst_fill", {20'd0, bus.color_out}, 32'h0);
      pixelPulses(1);
      checkOutput("rst_valid", {20'd0, bus.color_out}, 32'h055);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
